uart_fifo_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_fifo_ctrl_sync_fifo.sv | 51 +++++
 rtl/uart_fifo_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared register map, CTRL/STATUS bit positions and TX FSM encoding for uart_fifo_ctrl.
package uart_pkg;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_TXD  = 2'd1;
    localparam logic [1:0] ADDR_RXD  = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    localparam int CTRL_SEND     = 0;
    localparam int CTRL_AUTO_TX  = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_TX_FLUSH = 3;
    localparam int CTRL_RX_FLUSH = 4;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_OVF   = 5;
    localparam int ST_TX_BUSY  = 6;
    localparam int ST_TX_CNT   = 8;
    localparam int ST_RX_CNT   = 16;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} tx_state_t;

endpackage

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
// Power-of-two synchronous FIFO with combinational head, occupancy count and one-cycle flush.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Register-mapped UART front end: TX/RX FIFOs, TX sequencing FSM, sticky overflow flags and irq.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_i,
    input  logic              rd_i,
    input  logic [1:0]        addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              irq_o,
    output logic              uart_tx_start_o,
    output logic [DATA_W-1:0] uart_tx_data_o,
    input  logic              uart_tx_rdy_i,
    input  logic              uart_rx_rdy_i,
    input  logic [DATA_W-1:0] uart_rx_data_i
);
    localparam int TXCW = $clog2(TX_DEPTH) + 1;
    localparam int RXCW = $clog2(RX_DEPTH) + 1;

    tx_state_t         state;
    logic              send, auto_tx, irq_en, tx_ovf, rx_ovf;
    logic [DATA_W-1:0] tx_data;
    logic              wr_ctrl, wr_txd, wr_stat, rd_rxd;
    logic              tx_flush, rx_flush, tx_pop;
    logic [DATA_W-1:0] tx_head, rx_head;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [TXCW-1:0]   tx_count;
    logic [RXCW-1:0]   rx_count;
    logic              tx_ovf_set, rx_ovf_set, send_done;
    logic [31:0]       status;
    logic              unused_wdata;

    assign unused_wdata = ^wdata_i;

    assign wr_ctrl  = wr_i && (addr_i == ADDR_CTRL);
    assign wr_txd   = wr_i && (addr_i == ADDR_TXD);
    assign wr_stat  = wr_i && (addr_i == ADDR_STAT);
    assign rd_rxd   = rd_i && (addr_i == ADDR_RXD);
    assign tx_flush = wr_ctrl && wdata_i[CTRL_TX_FLUSH];
    assign rx_flush = wr_ctrl && wdata_i[CTRL_RX_FLUSH];
    assign tx_pop   = (state == LOAD);

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk_i), .rst(rst_i), .push(wr_txd), .pop(tx_pop), .flush(tx_flush),
        .din(wdata_i[DATA_W-1:0]), .dout(tx_head), .full(tx_full), .empty(tx_empty),
        .count(tx_count)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk_i), .rst(rst_i), .push(uart_rx_rdy_i), .pop(rd_rxd), .flush(rx_flush),
        .din(uart_rx_data_i), .dout(rx_head), .full(rx_full), .empty(rx_empty),
        .count(rx_count)
    );

    // Flush beats a same-cycle push and must not be reported as an overflow.
    assign tx_ovf_set = wr_txd && tx_full && !tx_pop && !tx_flush;
    assign rx_ovf_set = uart_rx_rdy_i && rx_full && !rd_rxd && !rx_flush;

    assign send_done = tx_empty && !wr_txd &&
                       ((state == IDLE) || ((state == WAIT_DONE) && uart_tx_rdy_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            tx_data <= '0;
        end else begin
            case (state)
                IDLE: if (!tx_empty && (send || auto_tx) && uart_tx_rdy_i) begin
                    tx_data <= tx_head;
                    state   <= LOAD;
                end
                // A flush on the IDLE->LOAD edge leaves nothing to send.
                LOAD:      state <= tx_empty ? IDLE : START;
                START:     state <= WAIT_BUSY;
                WAIT_BUSY: if (!uart_tx_rdy_i) state <= WAIT_DONE;
                WAIT_DONE: if (uart_tx_rdy_i)  state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    assign uart_tx_start_o = (state == START);
    assign uart_tx_data_o  = tx_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            send    <= 1'b0;
            auto_tx <= 1'b0;
            irq_en  <= 1'b0;
            tx_ovf  <= 1'b0;
            rx_ovf  <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                send    <= wdata_i[CTRL_SEND];
                auto_tx <= wdata_i[CTRL_AUTO_TX];
                irq_en  <= wdata_i[CTRL_IRQ_EN];
            end else if (send_done) begin
                send <= 1'b0;
            end
            tx_ovf <= tx_ovf_set || (tx_ovf && !(wr_stat && wdata_i[ST_TX_OVF]));
            rx_ovf <= rx_ovf_set || (rx_ovf && !(wr_stat && wdata_i[ST_RX_OVF]));
            irq_o  <= irq_en && (!rx_empty || tx_ovf || rx_ovf);
        end
    end

    always_comb begin
        status                  = '0;
        status[ST_TX_EMPTY]     = tx_empty;
        status[ST_TX_FULL]      = tx_full;
        status[ST_RX_EMPTY]     = rx_empty;
        status[ST_RX_FULL]      = rx_full;
        status[ST_TX_OVF]       = tx_ovf;
        status[ST_RX_OVF]       = rx_ovf;
        status[ST_TX_BUSY]      = (state != IDLE);
        status[ST_TX_CNT +: 8]  = 8'(tx_count);
        status[ST_RX_CNT +: 8]  = 8'(rx_count);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (rd_i) begin
            case (addr_i)
                ADDR_CTRL: rdata_o <= 32'({irq_en, auto_tx, send});
                ADDR_RXD:  rdata_o <= rx_empty ? '0 : 32'(rx_head);
                ADDR_STAT: rdata_o <= status;
                default:   rdata_o <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench for uart_fifo_ctrl: stimulus queues expected reads/characters, a monitor checks them.
module tb_uart_fifo_ctrl;
    import uart_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wr_i = 1'b0, rd_i = 1'b0;
    logic [1:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        irq_o, uart_tx_start_o;
    logic [7:0]  uart_tx_data_o;
    logic        uart_tx_rdy_i = 1'b1, uart_rx_rdy_i = 1'b0;
    logic [7:0]  uart_rx_data_i = '0;

    int          errors = 0, checks = 0, starts = 0;
    logic [31:0] exp_rd[$];
    logic [7:0]  exp_tx[$];
    bit          rd_seen;
    int          m_pre = 0, m_busy = 0;
    bit          found;

    uart_fifo_ctrl #(.DATA_W(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_i(wr_i), .rd_i(rd_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .irq_o(irq_o),
        .uart_tx_start_o(uart_tx_start_o), .uart_tx_data_o(uart_tx_data_o),
        .uart_tx_rdy_i(uart_tx_rdy_i), .uart_rx_rdy_i(uart_rx_rdy_i),
        .uart_rx_data_i(uart_rx_data_i)
    );

    always #50 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1; wr_i = 1'b0; rd_i = 1'b0; uart_rx_rdy_i = 1'b0;
        cyc(3);
        rst_i = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        wr_i = 1'b1; addr_i = a; wdata_i = d;
        cyc(1);
        wr_i = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, input logic [31:0] e);
        rd_i = 1'b1; addr_i = a;
        exp_rd.push_back(e);
        cyc(1);
        rd_i = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        uart_rx_rdy_i = 1'b1; uart_rx_data_i = d;
        cyc(1);
        uart_rx_rdy_i = 1'b0;
    endtask

    // RX_DATA read and a received character in the same cycle.
    task automatic rd_rx(input logic [7:0] d, input logic [31:0] e);
        rd_i = 1'b1; addr_i = ADDR_RXD; uart_rx_rdy_i = 1'b1; uart_rx_data_i = d;
        exp_rd.push_back(e);
        cyc(1);
        rd_i = 1'b0; uart_rx_rdy_i = 1'b0;
    endtask

    task automatic wr_rx(input logic [31:0] ctrl, input logic [7:0] d);
        wr_i = 1'b1; addr_i = ADDR_CTRL; wdata_i = ctrl;
        uart_rx_rdy_i = 1'b1; uart_rx_data_i = d;
        cyc(1);
        wr_i = 1'b0; uart_rx_rdy_i = 1'b0;
    endtask

    task automatic wait_start(output bit f);
        f = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (uart_tx_start_o) begin
                f = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tx_drain();
        for (int i = 0; i < 400 && exp_tx.size() != 0; i++) cyc(1);
        chk("tx_drain", exp_tx.size(), 0);
    endtask

    // UART core model: idle 2 cycles after the start pulse, then busy for 10.
    initial forever begin
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            m_pre = 0; m_busy = 0; uart_tx_rdy_i = 1'b1;
        end else if (m_pre > 0) begin
            m_pre--;
            if (m_pre == 0) begin
                uart_tx_rdy_i = 1'b0;
                m_busy = 10;
            end
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) uart_tx_rdy_i = 1'b1;
        end else if (uart_tx_start_o) begin
            m_pre = 2;
        end
    end

    initial forever begin
        @(posedge clk_i);
        rd_seen = rd_i;
        @(negedge clk_i);
        if (rd_seen) begin
            if (exp_rd.size() == 0) begin
                checks++; errors++;
                $display("FAIL rdata_unexpected: got 0x%0h with no read queued", rdata_o);
            end else begin
                chk("rdata", rdata_o, exp_rd.pop_front());
            end
        end
        if (uart_tx_start_o) begin
            starts++;
            if (exp_tx.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx_start_unexpected: data 0x%0h, required no pulse", uart_tx_data_o);
            end else begin
                chk("tx_data", uart_tx_data_o, exp_tx.pop_front());
            end
        end
    end

    initial begin
        // reset state
        do_reset();
        chk("rst_irq", irq_o, 0);
        chk("rst_start", uart_tx_start_o, 0);
        chk("rst_txdata", uart_tx_data_o, 0);
        chk("rst_rdata", rdata_o, 0);
        rd_reg(ADDR_STAT, 32'h5);
        rd_reg(ADDR_CTRL, 32'h0);

        // send-mode transmission of three characters
        do_reset();
        starts = 0;
        for (int i = 0; i < 3; i++) begin
            wr_reg(ADDR_TXD, 32'h41 + i);
            exp_tx.push_back(8'h41 + 8'(i));
        end
        wr_reg(ADDR_CTRL, 32'h1);
        wait_tx_drain();
        cyc(20);
        chk("send_starts", starts, 3);
        rd_reg(ADDR_CTRL, 32'h0);
        rd_reg(ADDR_STAT, 32'h5);

        // TX overflow, sticky clear, flush
        do_reset();
        for (int i = 0; i < 17; i++) wr_reg(ADDR_TXD, 32'(i));
        rd_reg(ADDR_STAT, 32'h1016);
        wr_reg(ADDR_STAT, 32'h10);
        rd_reg(ADDR_STAT, 32'h1006);
        wr_reg(ADDR_CTRL, 32'h8);
        rd_reg(ADDR_STAT, 32'h5);
        rd_reg(ADDR_CTRL, 32'h0);

        // RX fill, irq latency, overflow, drain, empty read
        do_reset();
        wr_reg(ADDR_CTRL, 32'h4);
        chk("irq_idle", irq_o, 0);
        rx_pulse(8'h00);
        chk("irq_lat0", irq_o, 0);
        cyc(1);
        chk("irq_lat1", irq_o, 1);
        for (int i = 1; i < 16; i++) rx_pulse(8'(i));
        rd_reg(ADDR_STAT, 32'h0010_0009);
        rx_pulse(8'hFF);
        rd_reg(ADDR_STAT, 32'h0010_0029);
        for (int i = 0; i < 16; i++) rd_reg(ADDR_RXD, 32'(i));
        rd_reg(ADDR_RXD, 32'h0);
        cyc(1);
        chk("irq_ovf", irq_o, 1);
        wr_reg(ADDR_STAT, 32'h20);
        cyc(2);
        chk("irq_clr", irq_o, 0);
        rd_reg(ADDR_STAT, 32'h5);

        // push and pop together while RX full; RX flush beats push
        do_reset();
        for (int i = 0; i < 16; i++) rx_pulse(8'h80 + 8'(i));
        rd_reg(ADDR_STAT, 32'h0010_0009);
        rd_rx(8'h55, 32'h80);
        rd_reg(ADDR_STAT, 32'h0010_0009);
        for (int i = 1; i < 16; i++) rd_reg(ADDR_RXD, 32'h80 + i);
        rd_reg(ADDR_RXD, 32'h55);
        rd_reg(ADDR_STAT, 32'h5);
        for (int i = 0; i < 16; i++) rx_pulse(8'(i));
        wr_rx(32'h10, 8'h66);
        rd_reg(ADDR_STAT, 32'h5);

        // auto_tx with flush during WAIT_BUSY of the first character
        do_reset();
        starts = 0;
        for (int i = 0; i < 4; i++) wr_reg(ADDR_TXD, 32'h61 + i);
        exp_tx.push_back(8'h61);
        wr_reg(ADDR_CTRL, 32'h2);
        wait_start(found);
        chk("auto_start_seen", found, 1);
        cyc(1);
        wr_reg(ADDR_CTRL, 32'hA);
        rd_reg(ADDR_STAT, 32'h45);
        cyc(30);
        chk("flush_starts", starts, 1);
        rd_reg(ADDR_STAT, 32'h5);
        rd_reg(ADDR_CTRL, 32'h2);

        // reset mid-frame aborts the FSM
        do_reset();
        wr_reg(ADDR_CTRL, 32'h2);
        wr_reg(ADDR_TXD, 32'h77);
        exp_tx.push_back(8'h77);
        wait_start(found);
        chk("mid_start_seen", found, 1);
        cyc(6);
        starts = 0;
        do_reset();
        chk("mid_rst_start", uart_tx_start_o, 0);
        chk("mid_rst_txdata", uart_tx_data_o, 0);
        rd_reg(ADDR_STAT, 32'h5);
        cyc(30);
        chk("mid_rst_starts", starts, 0);
        rd_reg(ADDR_CTRL, 32'h0);

        cyc(2);
        chk("rd_queue_left", exp_rd.size(), 0);
        chk("tx_queue_left", exp_tx.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
